instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Front end of the 9-bit core: holds the program counter and instruction memory and
//  supplies one 9-bit instruction per accept to the decode/execute controller via a
//  valid/ready handshake. Applies the controller's jump/branch redirects and stops on
//  the halt encoding. Includes a program-load write port for use while not running.
// PARAMETERS
//  PC_W       10        program counter width; imem depth = 2**PC_W words
//  INSTR_W    9         instruction width
//  OFF_W      6         signed branch offset width
//  CNT_W      16        retired-instruction counter width
//  START_PC   0         PC loaded on start
//  HALT_INSTR 9'h1FF    encoding that halts fetch
// PORTS
//  clk          in   1        clock, all state updates on posedge
//  reset        in   1        synchronous, active-low reset
//  start        in   1        pulse: begin fetching at START_PC (IDLE only)
//  prog_we      in   1        imem write enable (IDLE/HALT only)
//  prog_addr    in   PC_W     imem write address
//  prog_data    in   INSTR_W  imem write data
//  instr        out  INSTR_W  current instruction (registered)
//  instr_valid  out  1        instr holds a fetched instruction
//  instr_ready  in   1        controller consumes instr this cycle
//  pc           out  PC_W     address of instr
//  jump_en      in   1        absolute redirect, sampled on accept
//  jump_target  in   PC_W     absolute target
//  branch_en    in   1        relative redirect, sampled on accept
//  branch_off   in   OFF_W    signed offset from pc of accepted instr
//  halted       out  1        fetch stopped on HALT_INSTR
//  retired      out  CNT_W    count of accepted instructions, saturating
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, pc=0, instr=0, instr_valid=0, halted=0,
//    retired=0. imem contents are not reset. Reset overrides every other input.
//  - States: IDLE, RUN, HALT. accept = instr_valid & instr_ready (RUN only).
//  - IDLE: start -> pc<=START_PC, instr<=imem[START_PC], instr_valid<=1, state<=RUN;
//    instr_valid first seen 1 cycle after start. start ignored in RUN/HALT.
//  - RUN, no accept: pc, instr, instr_valid hold (stall). jump_en/branch_en ignored.
//  - RUN, accept, instr!=HALT_INSTR: npc = jump_en ? jump_target
//    : branch_en ? pc + sext(branch_off) : pc + 1; arithmetic mod 2**PC_W (wraps,
//    e.g. pc=2**PC_W-1 +1 -> 0). pc<=npc, instr<=imem[npc], instr_valid stays 1:
//    back-to-back accepts sustain one instruction per cycle. jump_en beats branch_en.
//  - RUN, accept, instr==HALT_INSTR: redirects ignored; pc holds, instr_valid<=0,
//    halted<=1, state<=HALT. HALT left only by reset.
//  - retired increments on every accept (halt included); saturates at 2**CNT_W-1.
//  - prog_we in IDLE/HALT: imem[prog_addr]<=prog_data at posedge. prog_we in RUN,
//    or in the same cycle as start, is ignored (no write).
//  - Reset mid-RUN: fetch aborts, outputs return to reset values next cycle; imem kept.
// TESTING
//  - Load imem[0..3]={9'h001,9'h002,9'h003,HALT}; start; ready=1 -> instr 001,002,003,
//    1FF on consecutive cycles, pc 0..3, then halted=1, instr_valid=0, retired=4.
//  - Same program, ready toggled 1,0,0,1 -> instr/pc hold during ready=0; no skips.
//  - Accept at pc=5 with branch_en=1, branch_off=-3 -> next pc=2; with jump_en=1,
//    jump_target=40 and branch_en=1 -> next pc=40.
//  - PC_W=4, pc=15, accept, no redirect -> pc=0, instr=imem[0].
//  - prog_we during RUN to addr of next instr -> fetched instr is old contents;
//    start+prog_we same cycle -> no write.
//  - reset=0 mid-RUN -> next cycle instr_valid=0, pc=0, retired=0, state IDLE; restart
//    fetches from START_PC with imem intact.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch <-> controller bundle: instruction handshake, redirects, status and program-load port.
interface instruction_fetch_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int OFF_W   = 6,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc;
  logic               jump_en;
  logic [PC_W-1:0]    jump_target;
  logic               branch_en;
  logic [OFF_W-1:0]   branch_off;
  logic               halted;
  logic [CNT_W-1:0]   retired;

  // master = fetch unit, slave = decode/execute controller and program loader
  modport master (
    input  start, prog_we, prog_addr, prog_data, instr_ready,
           jump_en, jump_target, branch_en, branch_off,
    output instr, instr_valid, pc, halted, retired
  );

  modport slave (
    output start, prog_we, prog_addr, prog_data, instr_ready,
           jump_en, jump_target, branch_en, branch_off,
    input  instr, instr_valid, pc, halted, retired
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch for the 9-bit core: PC, instruction memory, valid/ready delivery,
// jump/branch redirect, halt detection and a program-load port usable while stopped.
module instruction_fetch #(
  parameter int                  PC_W       = 10,
  parameter int                  INSTR_W    = 9,
  parameter int                  OFF_W      = 6,
  parameter int                  CNT_W      = 16,
  parameter logic [PC_W-1:0]     START_PC   = '0,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = 9'h1FF
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [INSTR_W-1:0] imem [2**PC_W];
  logic               mem_we;
  logic               accept;
  logic [PC_W-1:0]    npc;
  logic [31:0]        off_sext;

  assign accept   = valid_q && bus.instr_ready && (state_q == S_RUN);
  assign off_sext = {{(32-OFF_W){bus.branch_off[OFF_W-1]}}, bus.branch_off};

  always_comb begin
    npc = pc_q + 1'b1;
    if (bus.jump_en)
      npc = bus.jump_target;
    else if (bus.branch_en)
      npc = pc_q + off_sext[PC_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a load coinciding with start is dropped so the first fetch sees stable memory
        if (bus.start) begin
          pc_d    = START_PC;
          instr_d = imem[START_PC];
          valid_d = 1'b1;
          state_d = S_RUN;
        end else begin
          mem_we = bus.prog_we;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (retired_q != '1)
            retired_d = retired_q + 1'b1;
          if (instr_q == HALT_INSTR) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = npc;
            instr_d = imem[npc];
          end
        end
      end
      S_HALT: begin
        mem_we = bus.prog_we;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // memory contents survive reset; only the write itself is blocked while reset is low
  always_ff @(posedge clk) begin
    if (reset && mem_we)
      imem[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a default-size instance plus a PC_W=4/CNT_W=4
// instance for PC wrap and retired-counter saturation.
module tb_instruction_fetch;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instruction_fetch_if #(.PC_W(10), .INSTR_W(9), .OFF_W(6), .CNT_W(16)) ifa ();
  instruction_fetch_if #(.PC_W(4),  .INSTR_W(9), .OFF_W(6), .CNT_W(4))  ifw ();

  instruction_fetch #(.PC_W(10), .INSTR_W(9), .OFF_W(6), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  instruction_fetch #(.PC_W(4), .INSTR_W(9), .OFF_W(6), .CNT_W(4)) u_dut_w (
    .clk(clk), .reset(reset), .bus(ifw)
  );

  logic [8:0] prog [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic prog_write(input logic [9:0] addr, input logic [8:0] data);
    ifa.prog_we   = 1'b1;
    ifa.prog_addr = addr;
    ifa.prog_data = data;
    tick();
    ifa.prog_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ifa.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", ifa.instr_valid); end
    total++; if (ifa.pc !== 10'd0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", ifa.pc); end
    total++; if (ifa.instr !== 9'd0) begin bad++; $display("FAIL reset_instr got=%0h exp=0", ifa.instr); end
    total++; if (ifa.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0h exp=0", ifa.halted); end
    total++; if (ifa.retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0h exp=0", ifa.retired); end
  endtask

  task automatic test_straight();
    for (int i = 0; i < 4; i++) prog_write(10'(i), prog[i]);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifa.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ifa.pc !== 10'(i) || ifa.instr !== prog[i] || ifa.instr_valid !== 1'b1) begin
        bad++; $display("FAIL straight_step%0d got pc=%0h instr=%0h v=%0h exp pc=%0h instr=%0h v=1",
                        i, ifa.pc, ifa.instr, ifa.instr_valid, i, prog[i]);
      end
      tick();
    end
    ifa.instr_ready = 1'b0;
    total++; if (ifa.halted !== 1'b1 || ifa.instr_valid !== 1'b0) begin bad++; $display("FAIL straight_halt got h=%0h v=%0h exp h=1 v=0", ifa.halted, ifa.instr_valid); end
    total++; if (ifa.retired !== 16'd4) begin bad++; $display("FAIL straight_retired got=%0d exp=4", ifa.retired); end
    total++; if (ifa.pc !== 10'd3) begin bad++; $display("FAIL straight_halt_pc got=%0h exp=3", ifa.pc); end
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    total++; if (ifa.halted !== 1'b1 || ifa.instr_valid !== 1'b0) begin bad++; $display("FAIL halt_start_ignored got h=%0h v=%0h exp h=1 v=0", ifa.halted, ifa.instr_valid); end
  endtask

  task automatic test_stall();
    logic rdy [7];
    int   idx;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      ifa.instr_ready = rdy[k];
      // redirects offered only while stalled; they must have no effect
      ifa.jump_en     = !rdy[k];
      ifa.jump_target = 10'd40;
      total++; if (ifa.pc !== 10'(idx) || ifa.instr !== prog[idx]) begin
        bad++; $display("FAIL stall_cyc%0d got pc=%0h instr=%0h exp pc=%0h instr=%0h", k, ifa.pc, ifa.instr, idx, prog[idx]);
      end
      tick();
      if (rdy[k] && idx < 3) idx++;
    end
    ifa.instr_ready = 1'b0;
    ifa.jump_en     = 1'b0;
    total++; if (ifa.halted !== 1'b1 || ifa.retired !== 16'd4) begin bad++; $display("FAIL stall_end got h=%0h ret=%0d exp h=1 ret=4", ifa.halted, ifa.retired); end
  endtask

  task automatic test_redirect();
    do_reset();
    prog_write(10'd5, 9'h005);
    prog_write(10'd40, 9'h028);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifa.instr_ready = 1'b1;
    ifa.jump_en     = 1'b1;
    ifa.jump_target = 10'd5;
    tick();
    total++; if (ifa.pc !== 10'd5 || ifa.instr !== 9'h005) begin bad++; $display("FAIL jump_5 got pc=%0h instr=%0h exp pc=5 instr=005", ifa.pc, ifa.instr); end
    ifa.jump_en    = 1'b0;
    ifa.branch_en  = 1'b1;
    ifa.branch_off = 6'b111101;
    tick();
    total++; if (ifa.pc !== 10'd2 || ifa.instr !== 9'h003) begin bad++; $display("FAIL branch_m3 got pc=%0h instr=%0h exp pc=2 instr=003", ifa.pc, ifa.instr); end
    ifa.jump_en     = 1'b1;
    ifa.jump_target = 10'd40;
    tick();
    total++; if (ifa.pc !== 10'd40 || ifa.instr !== 9'h028) begin bad++; $display("FAIL jump_beats_branch got pc=%0h instr=%0h exp pc=28 instr=028", ifa.pc, ifa.instr); end
    total++; if (ifa.retired !== 16'd3) begin bad++; $display("FAIL redirect_retired got=%0d exp=3", ifa.retired); end
    ifa.branch_en   = 1'b0;
    ifa.jump_target = 10'd3;
    tick();
    ifa.jump_target = 10'd5;
    tick();
    ifa.jump_en     = 1'b0;
    ifa.instr_ready = 1'b0;
    total++; if (ifa.halted !== 1'b1 || ifa.pc !== 10'd3) begin bad++; $display("FAIL halt_ignores_jump got h=%0h pc=%0h exp h=1 pc=3", ifa.halted, ifa.pc); end
  endtask

  task automatic test_prog_run();
    do_reset();
    prog_write(10'd7, 9'h070);
    ifa.start     = 1'b1;
    ifa.prog_we   = 1'b1;
    ifa.prog_addr = 10'd7;
    ifa.prog_data = 9'h077;
    tick();
    ifa.start     = 1'b0;
    ifa.prog_addr = 10'd1;
    ifa.prog_data = 9'h111;
    tick();
    ifa.prog_we     = 1'b0;
    ifa.instr_ready = 1'b1;
    tick();
    total++; if (ifa.pc !== 10'd1 || ifa.instr !== 9'h002) begin bad++; $display("FAIL run_write_ignored got pc=%0h instr=%0h exp pc=1 instr=002", ifa.pc, ifa.instr); end
    ifa.jump_en     = 1'b1;
    ifa.jump_target = 10'd7;
    tick();
    ifa.jump_en     = 1'b0;
    ifa.instr_ready = 1'b0;
    total++; if (ifa.pc !== 10'd7 || ifa.instr !== 9'h070) begin bad++; $display("FAIL start_write_ignored got pc=%0h instr=%0h exp pc=7 instr=070", ifa.pc, ifa.instr); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++; if (ifa.instr_valid !== 1'b0 || ifa.pc !== 10'd0 || ifa.retired !== 16'd0 || ifa.instr !== 9'd0) begin
      bad++; $display("FAIL midrun_reset got v=%0h pc=%0h ret=%0d instr=%0h exp v=0 pc=0 ret=0 instr=0", ifa.instr_valid, ifa.pc, ifa.retired, ifa.instr);
    end
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    total++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd0 || ifa.instr !== 9'h001) begin bad++; $display("FAIL restart got v=%0h pc=%0h instr=%0h exp v=1 pc=0 instr=001", ifa.instr_valid, ifa.pc, ifa.instr); end
    ifa.instr_ready = 1'b1;
    tick();
    ifa.instr_ready = 1'b0;
    total++; if (ifa.pc !== 10'd1 || ifa.instr !== 9'h002) begin bad++; $display("FAIL restart_imem_kept got pc=%0h instr=%0h exp pc=1 instr=002", ifa.pc, ifa.instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ifw.prog_we   = 1'b1;
      ifw.prog_addr = 4'(i);
      ifw.prog_data = 9'h100 + 9'(i);
      tick();
    end
    ifw.prog_we = 1'b0;
    ifw.start   = 1'b1;
    tick();
    ifw.start       = 1'b0;
    ifw.instr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (ifw.pc !== 4'(i)) begin bad++; $display("FAIL wrap_step%0d got pc=%0h exp=%0h", i, ifw.pc, i); end
      tick();
    end
    total++; if (ifw.pc !== 4'd0 || ifw.instr !== 9'h100) begin bad++; $display("FAIL wrap_to_0 got pc=%0h instr=%0h exp pc=0 instr=100", ifw.pc, ifw.instr); end
    total++; if (ifw.retired !== 4'd15) begin bad++; $display("FAIL retired_sat got=%0d exp=15", ifw.retired); end
    ifw.branch_en  = 1'b1;
    ifw.branch_off = 6'b111101;
    tick();
    ifw.branch_en   = 1'b0;
    ifw.instr_ready = 1'b0;
    total++; if (ifw.pc !== 4'd13 || ifw.instr !== 9'h10D || ifw.retired !== 4'd15) begin
      bad++; $display("FAIL wrap_branch got pc=%0h instr=%0h ret=%0d exp pc=d instr=10d ret=15", ifw.pc, ifw.instr, ifw.retired);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prog  = '{9'h001, 9'h002, 9'h003, 9'h1FF};
    reset = 1'b0;
    {ifa.start, ifa.prog_we, ifa.instr_ready, ifa.jump_en, ifa.branch_en} = '0;
    ifa.prog_addr = '0; ifa.prog_data = '0; ifa.jump_target = '0; ifa.branch_off = '0;
    {ifw.start, ifw.prog_we, ifw.instr_ready, ifw.jump_en, ifw.branch_en} = '0;
    ifw.prog_addr = '0; ifw.prog_data = '0; ifw.jump_target = '0; ifw.branch_off = '0;

    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_prog_run();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
